// File: rtl/lii_mem_responder.sv
// lii_mem_responder
//   LII target endpoint at the memory node. Terminates READ/WRITE request
//   packets from the AXI-to-LII initiator wrapper and serves them from a local
//   byte-wide synchronous RAM. READs return one data flit per beat. WRITEs
//   return a single ack flit.
//
//   Header flit, MSB-first from tdata[LII_DW-1]:
//     op[2] len[8] size[3] addr[AXI_AW] tag[8]
//     op: 00 READ, 01 WRITE, 1x invalid
//   Beats = len+1. Beat address = addr + beat index. Beats at or above
//   2**MEM_AW read as zero, are dropped on write, and flag an error.
//
//   Optional build macro: LII_RESP_TAG_EN
//     defined   - every response flit carries the request tag in tdata[LII_DW-1 -: 8]
//     undefined - those bits are zero
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   lii_req_*           request stream in (tstrb, dst ignored; tkeep[0] = write strobe)
//   lii_resp_*          response stream out (tkeep=0 marks a write ack)
//   cfg_src             this node's id, driven on lii_resp_src
module lii_mem_responder #(
  parameter int AXI_AW = 48,
  parameter int AXI_DW = 8,
  parameter int LII_DW = 1024,
  parameter int MEM_AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LII_DW-1:0]   lii_req_tdata,
  input  logic [LII_DW/8-1:0] lii_req_tkeep,
  input  logic [LII_DW/8-1:0] lii_req_tstrb,
  input  logic                lii_req_tlast,
  input  logic [7:0]          lii_req_src,
  input  logic [7:0]          lii_req_dst,
  input  logic                lii_req_tvalid,
  output logic                lii_req_tready,
  output logic [LII_DW-1:0]   lii_resp_tdata,
  output logic [LII_DW/8-1:0] lii_resp_tkeep,
  output logic [LII_DW/8-1:0] lii_resp_tstrb,
  output logic                lii_resp_tlast,
  output logic [7:0]          lii_resp_src,
  output logic [7:0]          lii_resp_dst,
  output logic                lii_resp_tvalid,
  input  logic                lii_resp_tready,
  input  logic [7:0]          cfg_src
);

  localparam int KW      = LII_DW / 8;
  localparam int BW      = AXI_DW / 8;
  localparam int OP_HI   = LII_DW - 1;
  localparam int LEN_HI  = LII_DW - 3;
  localparam int SIZE_HI = LII_DW - 11;
  localparam int ADDR_HI = LII_DW - 14;
  localparam int TAG_HI  = LII_DW - 14 - AXI_AW;

  localparam logic [KW-1:0] RD_KEEP = {{(KW-BW){1'b0}}, {BW{1'b1}}};

`ifdef LII_RESP_TAG_EN
  localparam logic [7:0] TAG_MASK = 8'hFF;
`else
  localparam logic [7:0] TAG_MASK = 8'h00;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_DROP,
    WDATA,
    DRAIN,
    WACK,
    RD_FETCH,
    RD_SEND
  } state_t;

  state_t              state;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [AXI_AW-1:0]   addr_q;
  logic [7:0]          tag_q;
  logic [8:0]          idx;
  logic                err_q;

  logic [1:0]          hdr_op;
  logic [7:0]          hdr_len;
  logic [2:0]          hdr_size;
  logic [AXI_AW-1:0]   hdr_addr;
  logic [7:0]          hdr_tag;

  logic [AXI_AW:0]     beat_addr;
  logic                in_range;
  logic [MEM_AW-1:0]   mem_idx;
  logic                last_beat;
  logic                req_hs;
  logic                resp_hs;
  logic                mem_we;
  logic                unused_bits;

  logic [AXI_DW-1:0]   mem [2**MEM_AW];

  assign hdr_op   = lii_req_tdata[OP_HI   -: 2];
  assign hdr_len  = lii_req_tdata[LEN_HI  -: 8];
  assign hdr_size = lii_req_tdata[SIZE_HI -: 3];
  assign hdr_addr = lii_req_tdata[ADDR_HI -: AXI_AW];
  assign hdr_tag  = lii_req_tdata[TAG_HI  -: 8];

  // One extra bit so addr + index never wraps back into range.
  assign beat_addr = {1'b0, addr_q} + {{(AXI_AW-8){1'b0}}, idx};
  assign in_range  = (beat_addr[AXI_AW:MEM_AW] == '0);
  assign mem_idx   = beat_addr[MEM_AW-1:0];
  assign last_beat = (idx == {1'b0, len_q});

  assign req_hs  = lii_req_tvalid & lii_req_tready;
  assign resp_hs = lii_resp_tvalid & lii_resp_tready;

  assign lii_resp_src = cfg_src;

  assign mem_we = (state == WDATA) && req_hs && lii_req_tkeep[0] && in_range;

  assign unused_bits = ^{lii_req_tstrb, lii_req_dst, lii_req_tkeep[KW-1:1], size_q};

  function automatic logic [LII_DW-1:0] ack_flit(input logic slverr, input logic [7:0] tag);
    logic [LII_DW-1:0] f;
    f = '0;
    f[1:0] = slverr ? 2'b10 : 2'b00;
    f[LII_DW-1 -: 8] = tag & TAG_MASK;
    return f;
  endfunction

  function automatic logic [LII_DW-1:0] rd_flit(input logic [AXI_DW-1:0] d, input logic [7:0] tag);
    logic [LII_DW-1:0] f;
    f = '0;
    f[AXI_DW-1:0] = d;
    f[LII_DW-1 -: 8] = tag & TAG_MASK;
    return f;
  endfunction

  // RAM contents survive reset, so the array lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= lii_req_tdata[AXI_DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      len_q           <= '0;
      size_q          <= '0;
      addr_q          <= '0;
      tag_q           <= '0;
      idx             <= '0;
      err_q           <= 1'b0;
      lii_req_tready  <= 1'b0;
      lii_resp_tdata  <= '0;
      lii_resp_tkeep  <= '0;
      lii_resp_tstrb  <= '0;
      lii_resp_tlast  <= 1'b0;
      lii_resp_dst    <= '0;
      lii_resp_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lii_req_tready <= 1'b1;
          if (req_hs) begin
            len_q        <= hdr_len;
            size_q       <= hdr_size;
            addr_q       <= hdr_addr;
            tag_q        <= hdr_tag;
            lii_resp_dst <= lii_req_src;
            idx          <= '0;
            err_q        <= 1'b0;
            if (hdr_op == 2'b00) begin
              if (lii_req_tlast) begin
                state          <= RD_FETCH;
                lii_req_tready <= 1'b0;
              end else begin
                state <= RD_DROP;
                err_q <= 1'b1;
              end
            end else if (hdr_op == 2'b01 && !lii_req_tlast) begin
              state <= WDATA;
            end else if (!lii_req_tlast) begin
              state <= DRAIN;
            end else begin
              // Header-only WRITE or invalid op: ack straight away with the
              // tag taken from the flit being accepted.
              state           <= WACK;
              lii_req_tready  <= 1'b0;
              lii_resp_tdata  <= ack_flit(1'b1, hdr_tag);
              lii_resp_tkeep  <= '0;
              lii_resp_tstrb  <= '0;
              lii_resp_tlast  <= 1'b1;
              lii_resp_tvalid <= 1'b1;
            end
          end
        end

        RD_DROP: begin
          if (req_hs && lii_req_tlast) begin
            state          <= RD_FETCH;
            lii_req_tready <= 1'b0;
          end
        end

        WDATA: begin
          if (req_hs) begin
            if (!in_range) err_q <= 1'b1;
            if (last_beat && !lii_req_tlast) begin
              state <= DRAIN;
            end else if (lii_req_tlast) begin
              state           <= WACK;
              lii_req_tready  <= 1'b0;
              lii_resp_tdata  <= ack_flit(!last_beat || err_q || !in_range, tag_q);
              lii_resp_tkeep  <= '0;
              lii_resp_tstrb  <= '0;
              lii_resp_tlast  <= 1'b1;
              lii_resp_tvalid <= 1'b1;
            end else begin
              idx <= idx + 9'd1;
            end
          end
        end

        DRAIN: begin
          if (req_hs && lii_req_tlast) begin
            state           <= WACK;
            lii_req_tready  <= 1'b0;
            lii_resp_tdata  <= ack_flit(1'b1, tag_q);
            lii_resp_tkeep  <= '0;
            lii_resp_tstrb  <= '0;
            lii_resp_tlast  <= 1'b1;
            lii_resp_tvalid <= 1'b1;
          end
        end

        WACK: begin
          if (resp_hs) begin
            state           <= IDLE;
            lii_req_tready  <= 1'b1;
            lii_resp_tvalid <= 1'b0;
            lii_resp_tlast  <= 1'b0;
          end
        end

        // The RAM read lands directly in the response register, giving the
        // one-cycle read latency without a separate RAM output stage.
        RD_FETCH: begin
          state           <= RD_SEND;
          if (!in_range) err_q <= 1'b1;
          lii_resp_tdata  <= rd_flit(in_range ? mem[mem_idx] : '0, tag_q);
          lii_resp_tkeep  <= RD_KEEP;
          lii_resp_tstrb  <= RD_KEEP;
          lii_resp_tlast  <= last_beat;
          lii_resp_tvalid <= 1'b1;
        end

        RD_SEND: begin
          if (resp_hs) begin
            lii_resp_tvalid <= 1'b0;
            lii_resp_tlast  <= 1'b0;
            if (last_beat) begin
              state          <= IDLE;
              lii_req_tready <= 1'b1;
            end else begin
              idx   <= idx + 9'd1;
              state <= RD_FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lii_mem_responder.sv
module tb_lii_mem_responder;

  localparam int LII_DW = 1024;
  localparam int KW     = LII_DW / 8;

  localparam logic [KW-1:0] K1 = 1;
  localparam logic [KW-1:0] K0 = 0;
  localparam logic [7:0] NODE_ID = 8'h33;
  localparam logic [7:0] REQ_ID  = 8'h47;

`ifdef LII_RESP_TAG_EN
  localparam logic [7:0] TAG_MASK = 8'hFF;
`else
  localparam logic [7:0] TAG_MASK = 8'h00;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [LII_DW-1:0] lii_req_tdata;
  logic [KW-1:0]     lii_req_tkeep;
  logic [KW-1:0]     lii_req_tstrb;
  logic              lii_req_tlast;
  logic [7:0]        lii_req_src;
  logic [7:0]        lii_req_dst;
  logic              lii_req_tvalid;
  logic              lii_req_tready;
  logic [LII_DW-1:0] lii_resp_tdata;
  logic [KW-1:0]     lii_resp_tkeep;
  logic [KW-1:0]     lii_resp_tstrb;
  logic              lii_resp_tlast;
  logic [7:0]        lii_resp_src;
  logic [7:0]        lii_resp_dst;
  logic              lii_resp_tvalid;
  logic              lii_resp_tready;
  logic [7:0]        cfg_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lii_mem_responder #(
    .AXI_AW(48),
    .AXI_DW(8),
    .LII_DW(LII_DW),
    .MEM_AW(12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lii_req_tdata  (lii_req_tdata),
    .lii_req_tkeep  (lii_req_tkeep),
    .lii_req_tstrb  (lii_req_tstrb),
    .lii_req_tlast  (lii_req_tlast),
    .lii_req_src    (lii_req_src),
    .lii_req_dst    (lii_req_dst),
    .lii_req_tvalid (lii_req_tvalid),
    .lii_req_tready (lii_req_tready),
    .lii_resp_tdata (lii_resp_tdata),
    .lii_resp_tkeep (lii_resp_tkeep),
    .lii_resp_tstrb (lii_resp_tstrb),
    .lii_resp_tlast (lii_resp_tlast),
    .lii_resp_src   (lii_resp_src),
    .lii_resp_dst   (lii_resp_dst),
    .lii_resp_tvalid(lii_resp_tvalid),
    .lii_resp_tready(lii_resp_tready),
    .cfg_src        (cfg_src)
  );

  function automatic logic [LII_DW-1:0] hdr(input logic [1:0] op, input logic [7:0] len,
                                            input logic [47:0] addr, input logic [7:0] tag);
    logic [LII_DW-1:0] h;
    h = '0;
    h[1023:1022] = op;
    h[1021:1014] = len;
    h[1013:1011] = 3'd0;
    h[1010:963]  = addr;
    h[962:955]   = tag;
    return h;
  endfunction

  // Data flits carry junk in the top byte; only the low byte is payload.
  function automatic logic [LII_DW-1:0] dat(input logic [7:0] d);
    logic [LII_DW-1:0] f;
    f = '0;
    f[7:0] = d;
    f[1023:1016] = 8'hFF;
    return f;
  endfunction

  function automatic logic [LII_DW-1:0] rdf(input logic [7:0] d, input logic [7:0] tag);
    logic [LII_DW-1:0] f;
    f = '0;
    f[7:0] = d;
    f[1023:1016] = tag & TAG_MASK;
    return f;
  endfunction

  function automatic logic [LII_DW-1:0] ackf(input logic [1:0] resp, input logic [7:0] tag);
    logic [LII_DW-1:0] f;
    f = '0;
    f[1:0] = resp;
    f[1023:1016] = tag & TAG_MASK;
    return f;
  endfunction

  task automatic chk(input string name, input logic [LII_DW-1:0] obs, input logic [LII_DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed hi8=%h lo64=%h expected hi8=%h lo64=%h",
             name, obs[LII_DW-1 -: 8], obs[63:0], exp[LII_DW-1 -: 8], exp[63:0]);
    end
  endtask

  task automatic send(input logic [LII_DW-1:0] d, input logic [KW-1:0] k, input logic last);
    int n;
    lii_req_tdata  = d;
    lii_req_tkeep  = k;
    lii_req_tlast  = last;
    lii_req_tvalid = 1'b1;
    n = 0;
    while (lii_req_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_tready", lii_req_tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    lii_req_tvalid = 1'b0;
    lii_req_tlast  = 1'b0;
  endtask

  task automatic recv(input logic [7:0] d, input logic last, input logic [7:0] tag);
    int n;
    n = 0;
    while (lii_resp_tvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_valid", lii_resp_tvalid, 1'b1);
    chk("rd_data",  lii_resp_tdata, rdf(d, tag));
    chk("rd_keep",  lii_resp_tkeep, K1);
    chk("rd_strb",  lii_resp_tstrb, K1);
    chk("rd_last",  lii_resp_tlast, last);
    chk("rd_dst",   lii_resp_dst, REQ_ID);
    @(negedge clk);
  endtask

  // Called on the negedge right after the final request flit handshake.
  task automatic ack(input logic [1:0] resp, input logic [7:0] tag);
    chk("ack_valid", lii_resp_tvalid, 1'b1);
    chk("ack_data",  lii_resp_tdata, ackf(resp, tag));
    chk("ack_keep",  lii_resp_tkeep, K0);
    chk("ack_strb",  lii_resp_tstrb, K0);
    chk("ack_last",  lii_resp_tlast, 1'b1);
    chk("ack_dst",   lii_resp_dst, REQ_ID);
    chk("ack_src",   lii_resp_src, NODE_ID);
    chk("ack_ready_low", lii_req_tready, 1'b0);
    @(negedge clk);
    chk("ack_done", lii_resp_tvalid, 1'b0);
  endtask

  initial begin
    logic [7:0] exp8 [8];
    logic [LII_DW-1:0] prev_data;
    logic prev_last;
    logic prev_stall;
    int beat;
    int cyc;
    int n;

    exp8 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};

    rst             = 1'b1;
    cfg_src         = NODE_ID;
    lii_req_src     = REQ_ID;
    lii_req_dst     = 8'h99;
    lii_req_tdata   = '0;
    lii_req_tkeep   = '0;
    lii_req_tstrb   = '1;
    lii_req_tlast   = 1'b0;
    lii_req_tvalid  = 1'b0;
    lii_resp_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", lii_resp_tvalid, 1'b0);
    chk("rst_tlast",  lii_resp_tlast, 1'b0);
    chk("rst_tdata",  lii_resp_tdata, '0);
    chk("rst_tkeep",  lii_resp_tkeep, K0);
    chk("rst_tstrb",  lii_resp_tstrb, K0);
    chk("rst_tready", lii_req_tready, 1'b0);
    chk("rst_dst",    lii_resp_dst, 8'h00);
    chk("rst_src",    lii_resp_src, NODE_ID);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", lii_req_tready, 1'b1);

    // WRITE 0x10 len=3, four beats, OKAY ack one cycle after last beat
    send(hdr(2'b01, 8'd3, 48'h10, 8'h5C), K1, 1'b0);
    send(dat(8'hA1), K1, 1'b0);
    send(dat(8'hA2), K1, 1'b0);
    send(dat(8'hA3), K1, 1'b0);
    send(dat(8'hA4), K1, 1'b1);
    ack(2'b00, 8'h5C);

    // READ 0x10 len=3, first data two cycles after header
    send(hdr(2'b00, 8'd3, 48'h10, 8'h5C), K1, 1'b1);
    chk("rd_lat_c1", lii_resp_tvalid, 1'b0);
    @(negedge clk);
    chk("rd_lat_c2", lii_resp_tvalid, 1'b1);
    recv(8'hA1, 1'b0, 8'h5C);
    recv(8'hA2, 1'b0, 8'h5C);
    recv(8'hA3, 1'b0, 8'h5C);
    recv(8'hA4, 1'b1, 8'h5C);
    chk("rd_end_valid", lii_resp_tvalid, 1'b0);
    chk("rd_end_ready", lii_req_tready, 1'b1);

    // Burst crossing the top of memory
    send(hdr(2'b01, 8'd1, 48'hFFF, 8'h21), K1, 1'b0);
    send(dat(8'h77), K1, 1'b0);
    send(dat(8'h88), K1, 1'b1);
    ack(2'b10, 8'h21);
    send(hdr(2'b00, 8'd1, 48'hFFF, 8'h22), K1, 1'b1);
    recv(8'h77, 1'b0, 8'h22);
    recv(8'h00, 1'b1, 8'h22);

    // Early tlast on a len=3 write
    send(hdr(2'b01, 8'd3, 48'h20, 8'h31), K1, 1'b0);
    send(dat(8'h11), K1, 1'b0);
    send(dat(8'h22), K1, 1'b1);
    ack(2'b10, 8'h31);

    // len=0 write with two surplus beats drained
    send(hdr(2'b01, 8'd0, 48'h30, 8'h32), K1, 1'b0);
    send(dat(8'h55), K1, 1'b0);
    chk("drain_no_ack", lii_resp_tvalid, 1'b0);
    send(dat(8'h66), K1, 1'b0);
    chk("drain_no_ack2", lii_resp_tvalid, 1'b0);
    send(dat(8'h67), K1, 1'b1);
    ack(2'b10, 8'h32);

    // Partial writes stay committed
    send(hdr(2'b00, 8'd1, 48'h20, 8'h33), K1, 1'b1);
    recv(8'h11, 1'b0, 8'h33);
    recv(8'h22, 1'b1, 8'h33);
    send(hdr(2'b00, 8'd0, 48'h30, 8'h34), K1, 1'b1);
    recv(8'h55, 1'b1, 8'h34);

    // Fill 0x14..0x17, then a keep=0 beat must leave 0x16 untouched
    send(hdr(2'b01, 8'd3, 48'h14, 8'h40), K1, 1'b0);
    send(dat(8'hC5), K1, 1'b0);
    send(dat(8'hC6), K1, 1'b0);
    send(dat(8'hC7), K1, 1'b0);
    send(dat(8'hC8), K1, 1'b1);
    ack(2'b00, 8'h40);
    send(hdr(2'b01, 8'd0, 48'h16, 8'h41), K1, 1'b0);
    send(dat(8'hEE), K0, 1'b1);
    ack(2'b00, 8'h41);

    // Invalid opcodes
    send(hdr(2'b10, 8'd0, 48'h0, 8'h42), K1, 1'b1);
    ack(2'b10, 8'h42);
    send(hdr(2'b11, 8'd2, 48'h0, 8'h43), K1, 1'b0);
    send(dat(8'h00), K1, 1'b1);
    ack(2'b10, 8'h43);

    // READ len=7 under irregular 1/0 backpressure
    send(hdr(2'b00, 8'd7, 48'h10, 8'h5C), K1, 1'b1);
    beat = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (beat < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", lii_resp_tvalid, 1'b1);
        chk("stall_data",  lii_resp_tdata, prev_data);
        chk("stall_last",  lii_resp_tlast, prev_last);
      end
      if (lii_resp_tvalid) begin
        chk("rd8_data", lii_resp_tdata, rdf(exp8[beat], 8'h5C));
        chk("rd8_last", lii_resp_tlast, beat == 7);
      end
      lii_resp_tready = ((cyc % 3) != 0);
      prev_stall = lii_resp_tvalid && !lii_resp_tready;
      prev_data  = lii_resp_tdata;
      prev_last  = lii_resp_tlast;
      if (lii_resp_tvalid && lii_resp_tready) beat++;
    end
    chk("rd8_count", beat, 8);
    lii_resp_tready = 1'b1;
    @(negedge clk);
    chk("rd8_idle", lii_req_tready, 1'b1);

    // Reset while beat 4 is being presented
    send(hdr(2'b00, 8'd7, 48'h10, 8'h5D), K1, 1'b1);
    recv(8'hA1, 1'b0, 8'h5D);
    recv(8'hA2, 1'b0, 8'h5D);
    recv(8'hA3, 1'b0, 8'h5D);
    n = 0;
    while (lii_resp_tvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat4_data", lii_resp_tdata, rdf(8'hA4, 8'h5D));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tvalid", lii_resp_tvalid, 1'b0);
    chk("mid_rst_tdata",  lii_resp_tdata, '0);
    chk("mid_rst_tkeep",  lii_resp_tkeep, K0);
    chk("mid_rst_tlast",  lii_resp_tlast, 1'b0);
    chk("mid_rst_tready", lii_req_tready, 1'b0);
    chk("mid_rst_dst",    lii_resp_dst, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", lii_req_tready, 1'b1);

    // READ whose header is not tlast: trailing flit dropped, data returned
    send(hdr(2'b00, 8'd0, 48'h30, 8'h5E), K1, 1'b0);
    send(dat(8'h00), K1, 1'b1);
    recv(8'h55, 1'b1, 8'h5E);
    chk("final_idle", lii_req_tready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
